// File: rtl/spi_byte_sequencer_pkg.sv
// Shared types and defaults for the SPI byte sequencer and its FIFOs.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package spi_byte_sequencer_pkg;

  localparam int SEQ_DATA_W     = 8;
  localparam int SEQ_DEPTH_LOG2 = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } seq_state_e;

  function automatic int seq_depth(input int depth_log2);
    return 1 << depth_log2;
  endfunction

endpackage

// File: rtl/spi_seq_fifo.sv
// Synchronous FIFO with a separate occupancy counter; head is read combinationally.
// Latency: a pushed entry is visible at rdata the cycle after the push edge.
// Backpressure: push on full is dropped unless a pop happens the same cycle; pop on empty is ignored.
module spi_seq_fifo
  import spi_byte_sequencer_pkg::*;
#(
  parameter int DATA_W     = SEQ_DATA_W,
  parameter int DEPTH_LOG2 = SEQ_DEPTH_LOG2
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  push,
  input  logic [DATA_W-1:0]     wdata,
  input  logic                  pop,
  output logic [DATA_W-1:0]     rdata,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level
);

  localparam int DEPTH = seq_depth(DEPTH_LOG2);
  localparam logic [DEPTH_LOG2:0]   LVL_FULL = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   LVL_ONE  = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  logic [DATA_W-1:0]     mem_q [DEPTH];
  logic [DATA_W-1:0]     mem_d [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  logic                  push_ok, pop_ok;

  // Accept/reject decisions, storage write and pointer/level bookkeeping.
  // A pop frees the slot in the same cycle, so a push into a full FIFO
  // alongside a pop is accepted; it overwrites the entry being read out.
  always_comb begin
    pop_ok   = pop & (level_q != '0);
    push_ok  = push & ((level_q != LVL_FULL) | pop_ok);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    if (push_ok && !pop_ok) begin
      level_d = level_q + LVL_ONE;
    end else if (pop_ok && !push_ok) begin
      level_d = level_q - LVL_ONE;
    end
  end

  // Storage and pointers; storage is cleared so the head reads 0 after reset.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = (level_q == LVL_FULL);
  assign empty = (level_q == '0);
  assign level = level_q;

endmodule

// File: rtl/spi_byte_sequencer.sv
// Buffered byte engine: feeds queued TX bytes to the SPI core one at a time and stores replies in an RX FIFO.
// Latency: go 1 cycle after a start condition; next go no earlier than 2 cycles after done.
// Backpressure: no start while RX is full or TX is empty; optional SPI_SEQ_AUTO_SS_EN drives ssn automatically.
module spi_byte_sequencer
  import spi_byte_sequencer_pkg::*;
#(
  parameter int DATA_W     = SEQ_DATA_W,
  parameter int DEPTH_LOG2 = SEQ_DEPTH_LOG2
) (
  input  logic                PCLK,
  input  logic                PRESETn,
  input  logic                enable,
  input  logic [DATA_W-1:0]   tx_wdata,
  input  logic                tx_push,
  input  logic                rx_pop,
  output logic [DATA_W-1:0]   rx_rdata,
  output logic                tx_full,
  output logic                tx_empty,
  output logic                rx_full,
  output logic                rx_empty,
  output logic [DEPTH_LOG2:0] tx_level,
  output logic [DEPTH_LOG2:0] rx_level,
  output logic                tx_ovf,
  output logic                rx_unf,
  input  logic                clr_flags,
  input  logic                ss_force,
  output logic                ssn,
  output logic                busy,
  output logic                go,
  output logic [DATA_W-1:0]   datai,
  input  logic [DATA_W-1:0]   datao,
  input  logic                done,
  output logic                irq
);

  seq_state_e        state_q, state_d;
  logic              go_q, go_d;
  logic [DATA_W-1:0] datai_q, datai_d;
  logic              tx_ovf_q, tx_ovf_d;
  logic              rx_unf_q, rx_unf_d;
  logic [DATA_W-1:0] tx_rdata;
  logic              start;
  logic              done_ok;

  spi_seq_fifo #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_tx_fifo (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .push    (tx_push),
    .wdata   (tx_wdata),
    .pop     (start),
    .rdata   (tx_rdata),
    .full    (tx_full),
    .empty   (tx_empty),
    .level   (tx_level)
  );

  spi_seq_fifo #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_rx_fifo (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .push    (done_ok),
    .wdata   (datao),
    .pop     (rx_pop),
    .rdata   (rx_rdata),
    .full    (rx_full),
    .empty   (rx_empty),
    .level   (rx_level)
  );

  // Sequencer next state: start pops TX and latches the byte; done in the
  // go cycle is a core glitch and is ignored, as is any done while idle.
  always_comb begin
    start   = (state_q == ST_IDLE) & enable & ~tx_empty & ~rx_full;
    done_ok = (state_q == ST_BUSY) & ~go_q & done;
    state_d = state_q;
    go_d    = start;
    datai_d = datai_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_BUSY;
          datai_d = tx_rdata;
        end
      end
      ST_BUSY: begin
        if (done_ok) begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  // Sequencer FSM with registered go/datai.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= ST_IDLE;
      go_q    <= 1'b0;
      datai_q <= '0;
    end else begin
      state_q <= state_d;
      go_q    <= go_d;
      datai_q <= datai_d;
    end
  end

  // Sticky error flags; a clear in the same cycle as a new error wins.
  always_comb begin
    tx_ovf_d = tx_ovf_q | (tx_push & tx_full & ~start);
    rx_unf_d = rx_unf_q | (rx_pop & rx_empty);
    if (clr_flags) begin
      tx_ovf_d = 1'b0;
      rx_unf_d = 1'b0;
    end
  end

  // Flag registers.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      tx_ovf_q <= 1'b0;
      rx_unf_q <= 1'b0;
    end else begin
      tx_ovf_q <= tx_ovf_d;
      rx_unf_q <= rx_unf_d;
    end
  end

`ifdef SPI_SEQ_AUTO_SS_EN
  logic ss_sel_q, ss_sel_d;

  // Chip select follows the frame: asserted with the first go, held while a
  // transfer is in flight or bytes remain queued, released after the last done.
  always_comb begin
    ss_sel_d = start | (ss_sel_q & ((state_d == ST_BUSY) | ~tx_empty | tx_push));
  end

  // Automatic chip-select register.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      ss_sel_q <= 1'b0;
    end else begin
      ss_sel_q <= ss_sel_d;
    end
  end

  assign ssn = ~(ss_sel_q | ss_force);
`else
  assign ssn = ~ss_force;
`endif

  assign busy   = (state_q == ST_BUSY);
  assign go     = go_q;
  assign datai  = datai_q;
  assign tx_ovf = tx_ovf_q;
  assign rx_unf = rx_unf_q;
  assign irq    = (rx_level != '0) | tx_ovf_q | rx_unf_q;

endmodule
